if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_id_reg.sv | 40 ++++
 rtl/if_stage.sv | 122 ++++++++++++
 tb/tb_if_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch pipeline: fetch FSM states, PC stride
// and the canonical NOP used to fill squashed pipeline slots.
package if_stage_pkg;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_HALT  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [63:0] PC_INCR   = 64'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [63:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load on enable, squash to a NOP bubble on clear.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [63:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [63:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [63:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // Clear wins over enable; the held PC is left as-is on a squash.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (en_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch FSM and fetch counter
// feeding the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    output logic [63:0] Instruction_Address,
    input  logic [31:0] Instruction,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid,
    output logic        Fetch_Halted,
    output logic        Fetch_Fault,
    output logic [31:0] Fetch_Count
);

    localparam logic [64:0] LAST_BYTE = 65'(IMEM_BYTES) - 65'd1;

    fetch_state_e state_q;
    logic [63:0]  pc_q;
    logic [31:0]  count_q;
    logic         halted_q;
    logic         fault_q;

    logic fetchable;
    logic tgt_ok;
    logic ifid_en;
    logic ifid_clr;

    // 65-bit sum keeps addresses near 2^64 from wrapping into range.
    assign fetchable = (IMEM_BYTES >= 4) && (({1'b0, pc_q} + 65'd3) <= LAST_BYTE);
    assign tgt_ok    = is_word_aligned(Branch_Target);

    always_comb begin
        ifid_en  = 1'b0;
        ifid_clr = 1'b0;
        case (state_q)
            FS_RUN: begin
                if (Branch_Taken)    ifid_clr = 1'b1;
                else if (Stall)      ifid_clr = 1'b0;
                else if (!fetchable) ifid_clr = 1'b1;
                else if (Flush)      ifid_clr = 1'b1;
                else                 ifid_en  = 1'b1;
            end
            FS_HALT, FS_FAULT: ifid_clr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FS_BOOT;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_BOOT: state_q <= FS_RUN;
                FS_RUN: begin
                    if (Branch_Taken) begin
                        if (tgt_ok) begin
                            pc_q <= Branch_Target;
                        end else begin
                            state_q <= FS_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (!Stall) begin
                        if (!fetchable) begin
                            state_q  <= FS_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + PC_INCR;
                            if (!Flush && count_q != '1)
                                count_q <= count_q + 32'd1;
                        end
                    end
                end
                FS_HALT: begin
                    if (Branch_Taken) begin
                        halted_q <= 1'b0;
                        if (tgt_ok) begin
                            pc_q    <= Branch_Target;
                            state_q <= FS_RUN;
                        end else begin
                            state_q <= FS_FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                FS_FAULT: ;
                default:  state_q <= FS_FAULT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (ifid_en),
        .clr_i   (ifid_clr),
        .pc_i    (pc_q),
        .instr_i (Instruction),
        .pc_o    (IFID_PC),
        .instr_o (IFID_Instruction),
        .valid_o (IFID_Valid)
    );

    assign Instruction_Address = pc_q;
    assign Fetch_Halted        = halted_q;
    assign Fetch_Fault         = fault_q;
    assign Fetch_Count         = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a behavioural fetch model.
module tb_if_stage;

    localparam int          IMB = 101;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush, Branch_Taken;
    logic [63:0] Branch_Target;
    logic [63:0] Instruction_Address;
    logic [31:0] Instruction;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid, Fetch_Halted, Fetch_Fault;
    logic [31:0] Fetch_Count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:31];

    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_ins, m_cnt;
    bit          m_v, m_boot, m_halt, m_fault;

    always #5 clk = ~clk;

    always_comb begin
        if (Instruction_Address < 64'd128) Instruction = mem[Instruction_Address[6:2]];
        else                               Instruction = 32'hFFFF_FFFF;
    end

    if_stage #(.RESET_PC(64'd0), .IMEM_BYTES(IMB)) dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall               (Stall),
        .Flush               (Flush),
        .Branch_Taken        (Branch_Taken),
        .Branch_Target       (Branch_Target),
        .Instruction_Address (Instruction_Address),
        .Instruction         (Instruction),
        .IFID_PC             (IFID_PC),
        .IFID_Instruction    (IFID_Instruction),
        .IFID_Valid          (IFID_Valid),
        .Fetch_Halted        (Fetch_Halted),
        .Fetch_Fault         (Fetch_Fault),
        .Fetch_Count         (Fetch_Count)
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a < 64'd128) return mem[a[6:2]];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'd0; m_ipc = 64'd0; m_ins = 32'd0; m_cnt = 32'd0;
        m_v = 1'b0; m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
    endtask

    task automatic squash();
        m_v = 1'b0; m_ins = NOP;
    endtask

    // One clock edge of fetch behaviour, written from the fetch rules.
    task automatic model_edge(input bit st, input bit fl, input bit bt, input logic [63:0] tgt);
        bit aligned;
        aligned = (tgt % 4) == 0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_fault) begin
        end else if (m_halt) begin
            if (bt) begin
                m_halt = 1'b0;
                if (aligned) m_pc = tgt;
                else         m_fault = 1'b1;
            end
        end else if (bt) begin
            squash();
            if (aligned) m_pc = tgt;
            else         m_fault = 1'b1;
        end else if (st) begin
        end else if (m_pc > 64'(IMB - 4)) begin
            squash();
            m_halt = 1'b1;
        end else if (fl) begin
            squash();
            m_pc = m_pc + 64'd4;
        end else begin
            m_v = 1'b1; m_ipc = m_pc; m_ins = word_at(m_pc);
            m_pc = m_pc + 64'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic cmp_model(input string ctx);
        chk({ctx, ":addr"},   Instruction_Address, m_pc);
        chk({ctx, ":valid"},  64'(IFID_Valid), 64'(m_v));
        chk({ctx, ":instr"},  64'(IFID_Instruction), 64'(m_ins));
        chk({ctx, ":halted"}, 64'(Fetch_Halted), 64'(m_halt));
        chk({ctx, ":fault"},  64'(Fetch_Fault), 64'(m_fault));
        chk({ctx, ":count"},  64'(Fetch_Count), 64'(m_cnt));
        if (m_v) chk({ctx, ":ifid_pc"}, IFID_PC, m_ipc);
    endtask

    task automatic step(input string ctx, input bit st, input bit fl, input bit bt, input logic [63:0] tgt);
        Stall = st; Flush = fl; Branch_Taken = bt; Branch_Target = tgt;
        @(posedge clk);
        model_edge(st, fl, bt, tgt);
        #1;
        cmp_model(ctx);
    endtask

    task automatic chk_reset_vals(input string ctx);
        chk({ctx, ":addr"},    Instruction_Address, 64'd0);
        chk({ctx, ":ifid_pc"}, IFID_PC, 64'd0);
        chk({ctx, ":instr"},   64'(IFID_Instruction), 64'd0);
        chk({ctx, ":valid"},   64'(IFID_Valid), 64'd0);
        chk({ctx, ":halted"},  64'(Fetch_Halted), 64'd0);
        chk({ctx, ":fault"},   64'(Fetch_Fault), 64'd0);
        chk({ctx, ":count"},   64'(Fetch_Count), 64'd0);
    endtask

    task automatic do_reset();
        Stall = 1'b0; Flush = 1'b0; Branch_Taken = 1'b0; Branch_Target = 64'd0;
        reset = 1'b1;
        #2;
        model_reset();
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;

        do_reset();

        // Reset release and first two fetches
        step("boot", 0, 0, 0, 64'd0);
        chk("boot_valid", 64'(IFID_Valid), 64'd0);
        step("f0", 0, 0, 0, 64'd0);
        chk("f0_pc", IFID_PC, 64'd0);
        chk("f0_ins", 64'(IFID_Instruction), 64'h0050_0093);
        chk("f0_valid", 64'(IFID_Valid), 64'd1);
        step("f1", 0, 0, 0, 64'd0);
        chk("f1_pc", IFID_PC, 64'd4);
        chk("f1_ins", 64'(IFID_Instruction), 64'h00A0_0113);
        chk("f1_cnt", 64'(Fetch_Count), 64'd2);

        // Three stall cycles with Flush ignored, then resume
        for (int i = 0; i < 3; i++) step("stall", 1, i == 1, 0, 64'd0);
        chk("stall_addr", Instruction_Address, 64'd8);
        chk("stall_pc", IFID_PC, 64'd4);
        chk("stall_cnt", 64'(Fetch_Count), 64'd2);
        step("resume", 0, 0, 0, 64'd0);
        chk("resume_pc", IFID_PC, 64'd8);
        chk("resume_cnt", 64'(Fetch_Count), 64'd3);

        // Branch beats stall
        step("brst", 1, 0, 1, 64'h40);
        chk("brst_addr", Instruction_Address, 64'h40);
        chk("brst_valid", 64'(IFID_Valid), 64'd0);
        chk("brst_ins", 64'(IFID_Instruction), 64'(NOP));
        step("brst_next", 0, 0, 0, 64'd0);
        chk("brst_next_pc", IFID_PC, 64'h40);

        // Flush squashes but PC advances uncounted
        step("flush", 0, 1, 0, 64'd0);
        chk("flush_addr", Instruction_Address, 64'h48);
        chk("flush_cnt", 64'(Fetch_Count), 64'd4);

        // Randomized mix of stalls, flushes and aligned redirects
        for (int i = 0; i < 400; i++) begin
            bit st, fl, bt;
            logic [63:0] tgt;
            st  = ($urandom_range(0, 99) < 25);
            fl  = ($urandom_range(0, 99) < 15);
            bt  = ($urandom_range(0, 99) < 7);
            tgt = 64'($urandom_range(0, 31)) * 64'd4;
            step("rand", st, fl, bt, tgt);
        end

        // Run off the end of memory, then recover by branch
        do_reset();
        for (int i = 0; i < 26; i++) step("seq", 0, 0, 0, 64'd0);
        chk("seq_last_pc", IFID_PC, 64'h60);
        chk("seq_last_valid", 64'(IFID_Valid), 64'd1);
        chk("seq_cnt", 64'(Fetch_Count), 64'd25);
        step("halt", 0, 0, 0, 64'd0);
        chk("halt_flag", 64'(Fetch_Halted), 64'd1);
        chk("halt_addr", Instruction_Address, 64'h64);
        step("halt_hold", 0, 1, 0, 64'd0);
        chk("halt_hold_addr", Instruction_Address, 64'h64);
        step("halt_br", 0, 0, 1, 64'd0);
        chk("halt_br_flag", 64'(Fetch_Halted), 64'd0);
        chk("halt_br_addr", Instruction_Address, 64'd0);
        step("halt_resume", 0, 0, 0, 64'd0);
        chk("halt_resume_valid", 64'(IFID_Valid), 64'd1);

        // Asynchronous reset mid-run with a valid entry
        step("pre_rst", 0, 0, 0, 64'd0);
        chk("pre_rst_valid", 64'(IFID_Valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_reset_vals("async_rst");
        Branch_Taken = 1'b1; Branch_Target = 64'h20;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_held");
        @(negedge clk);
        reset = 1'b0;
        step("post_boot", 0, 0, 1, 64'h20);
        chk("post_boot_addr", Instruction_Address, 64'd0);
        step("post_f0", 0, 0, 0, 64'd0);
        chk("post_f0_pc", IFID_PC, 64'd0);

        // Misaligned redirect faults permanently until reset
        step("pre_flt", 0, 0, 0, 64'd0);
        step("flt", 0, 0, 1, 64'h42);
        chk("flt_flag", 64'(Fetch_Fault), 64'd1);
        chk("flt_addr", Instruction_Address, 64'd8);
        chk("flt_valid", 64'(IFID_Valid), 64'd0);
        step("flt_br", 0, 0, 1, 64'h10);
        chk("flt_br_addr", Instruction_Address, 64'd8);
        for (int i = 0; i < 3; i++) step("flt_idle", 0, 0, 0, 64'd0);
        chk("flt_cnt", 64'(Fetch_Count), 64'd2);
        do_reset();
        step("flt_clr_boot", 0, 0, 0, 64'd0);
        step("flt_clr_f0", 0, 0, 0, 64'd0);
        chk("flt_clr_valid", 64'(IFID_Valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
